// File: rtl/hdp_stream_receiver.sv
// hdp_stream_receiver
// Panel-side sink for the HDP LCD output stream. Locks to frame timing on the
// start-of-frame (rising update with valid), recovers pixel words with their
// word/line coordinates, flags framing violations and produces a per-frame
// checksum.
// Build option: define HDP_RX_CRC32_EN to make o_frameChecksum a CRC-32
// (poly 0x04C11DB7, init 0xFFFFFFFF, MSB first, no reflection, no final XOR)
// instead of the default 32-bit wrap-around sum. Ports are identical.

module hdp_stream_receiver #(
    parameter int WORDS_PER_LINE  = 40,
    parameter int BLANK_PER_LINE  = 4,
    parameter int LINES_PER_FRAME = 1280,
    parameter int BACK_PORCH      = 24,
    parameter int UPDATE_CYCLES   = 28
) (
    input  logic        i_clock,
    input  logic        i_nReset,
    input  logic        i_enable,
    input  logic [31:0] i_lcdData,
    input  logic        i_valid,
    input  logic        i_update,
    output logic [31:0] o_pixelData,
    output logic        o_pixelValid,
    output logic [15:0] o_wordIndex,
    output logic [15:0] o_lineIndex,
    output logic        o_lineDone,
    output logic        o_frameDone,
    output logic [31:0] o_frameChecksum,
    output logic        o_locked,
    output logic        o_frameError,
    output logic [15:0] o_errorCount
);

    localparam logic [1:0] S_HUNT  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_BLANK = 2'd2;
    localparam logic [1:0] S_PORCH = 2'd3;

    localparam logic [15:0] WORD_LAST  = 16'(WORDS_PER_LINE - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_PER_LINE - 1);
    localparam logic [15:0] LINE_LAST  = 16'(LINES_PER_FRAME - 1);
    localparam logic [15:0] PORCH_LAST = 16'(BACK_PORCH - 1);
    localparam logic [15:0] UPD_LEN    = 16'(UPDATE_CYCLES);

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
`ifdef HDP_RX_CRC32_EN
    localparam logic [31:0] CSUM_INIT = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] CSUM_INIT = 32'h0000_0000;
`endif

    // Fold one received word into the running frame checksum.
    function automatic logic [31:0] csum_step(input logic [31:0] acc, input logic [31:0] word);
`ifdef HDP_RX_CRC32_EN
        logic [31:0] crc;
        logic        fb;
        crc = acc;
        for (int i = 31; i >= 0; i--) begin
            fb  = crc[31] ^ word[i];
            crc = {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
        end
        return crc;
`else
        return acc + word;
`endif
    endfunction

    logic [1:0]  state_q, state_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic [15:0] phase_cnt_q, phase_cnt_d;   // blank or porch cycle counter
    logic [15:0] upd_cnt_q, upd_cnt_d;       // frame cycles seen, saturates at UPD_LEN
    logic        upd_prev_q;
    logic [31:0] csum_q, csum_d;

    logic [31:0] pix_data_q, pix_data_d;
    logic        pix_valid_q, pix_valid_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [15:0] line_idx_q, line_idx_d;
    logic        line_done_q, line_done_d;
    logic        frame_done_q, frame_done_d;
    logic [31:0] frame_csum_q, frame_csum_d;
    logic        locked_q, locked_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic sof_s;
    logic upd_bad_s;
    logic viol_s;

    assign sof_s     = i_update & ~upd_prev_q & i_valid;
    // update must be high for the first UPD_LEN frame cycles, low afterwards
    assign upd_bad_s = (i_update != (upd_cnt_q < UPD_LEN));

    // Frame tracking FSM, violation detection and output next-state logic.
    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        line_cnt_d   = line_cnt_q;
        phase_cnt_d  = phase_cnt_q;
        upd_cnt_d    = upd_cnt_q;
        csum_d       = csum_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = 1'b0;
        word_idx_d   = word_idx_q;
        line_idx_d   = line_idx_q;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        frame_csum_d = frame_csum_q;
        locked_d     = locked_q;
        frame_err_d  = 1'b0;
        err_cnt_d    = err_cnt_q;
        viol_s       = 1'b0;

        if (!i_enable) begin
            state_d  = S_HUNT;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                S_HUNT: begin
                    if (sof_s) begin
                        pix_data_d  = i_lcdData;
                        pix_valid_d = 1'b1;
                        word_idx_d  = 16'd0;
                        line_idx_d  = 16'd0;
                        csum_d      = csum_step(CSUM_INIT, i_lcdData);
                        line_cnt_d  = 16'd0;
                        upd_cnt_d   = 16'd1;
                        locked_d    = 1'b1;
                        if (WORD_LAST == 16'd0) begin
                            state_d     = S_BLANK;
                            phase_cnt_d = 16'd0;
                        end else begin
                            state_d    = S_DATA;
                            word_cnt_d = 16'd1;
                        end
                    end else begin
                        // a locked receiver expects the next frame immediately
                        viol_s = locked_q;
                    end
                end
                S_DATA: begin
                    viol_s = ~i_valid | sof_s | upd_bad_s;
                    if (!viol_s) begin
                        pix_data_d  = i_lcdData;
                        pix_valid_d = 1'b1;
                        word_idx_d  = word_cnt_q;
                        line_idx_d  = line_cnt_q;
                        csum_d      = csum_step(csum_q, i_lcdData);
                        if (word_cnt_q == WORD_LAST) begin
                            state_d     = S_BLANK;
                            phase_cnt_d = 16'd0;
                        end else begin
                            word_cnt_d = word_cnt_q + 16'd1;
                        end
                    end else begin
                        state_d = S_HUNT;
                    end
                end
                S_BLANK: begin
                    viol_s = i_valid | (i_lcdData != 32'd0) | upd_bad_s;
                    if (!viol_s) begin
                        if (phase_cnt_q == BLANK_LAST) begin
                            line_done_d = 1'b1;
                            phase_cnt_d = 16'd0;
                            if (line_cnt_q == LINE_LAST) begin
                                state_d = S_PORCH;
                            end else begin
                                state_d    = S_DATA;
                                line_cnt_d = line_cnt_q + 16'd1;
                                word_cnt_d = 16'd0;
                            end
                        end else begin
                            phase_cnt_d = phase_cnt_q + 16'd1;
                        end
                    end else begin
                        state_d = S_HUNT;
                    end
                end
                S_PORCH: begin
                    viol_s = i_valid | upd_bad_s;
                    if (!viol_s) begin
                        if (phase_cnt_q == PORCH_LAST) begin
                            frame_done_d = 1'b1;
                            frame_csum_d = csum_q;
                            state_d      = S_HUNT;
                        end else begin
                            phase_cnt_d = phase_cnt_q + 16'd1;
                        end
                    end else begin
                        state_d = S_HUNT;
                    end
                end
                default: begin
                    state_d  = S_HUNT;
                    locked_d = 1'b0;
                end
            endcase

            if ((state_q != S_HUNT) && (upd_cnt_q < UPD_LEN)) begin
                upd_cnt_d = upd_cnt_q + 16'd1;
            end else begin
                upd_cnt_d = upd_cnt_d;
            end

            if (viol_s) begin
                state_d     = S_HUNT;
                locked_d    = 1'b0;
                frame_err_d = 1'b1;
                err_cnt_d   = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
            end else begin
                frame_err_d = 1'b0;
            end
        end
    end

    // State, counter and output registers with asynchronous reset.
    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            state_q      <= S_HUNT;
            word_cnt_q   <= 16'd0;
            line_cnt_q   <= 16'd0;
            phase_cnt_q  <= 16'd0;
            upd_cnt_q    <= 16'd0;
            upd_prev_q   <= 1'b0;
            csum_q       <= 32'd0;
            pix_data_q   <= 32'd0;
            pix_valid_q  <= 1'b0;
            word_idx_q   <= 16'd0;
            line_idx_q   <= 16'd0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_csum_q <= 32'd0;
            locked_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            line_cnt_q   <= line_cnt_d;
            phase_cnt_q  <= phase_cnt_d;
            upd_cnt_q    <= upd_cnt_d;
            upd_prev_q   <= i_update;
            csum_q       <= csum_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            word_idx_q   <= word_idx_d;
            line_idx_q   <= line_idx_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            frame_csum_q <= frame_csum_d;
            locked_q     <= locked_d;
            frame_err_q  <= frame_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign o_pixelData     = pix_data_q;
    assign o_pixelValid    = pix_valid_q;
    assign o_wordIndex     = word_idx_q;
    assign o_lineIndex     = line_idx_q;
    assign o_lineDone      = line_done_q;
    assign o_frameDone     = frame_done_q;
    assign o_frameChecksum = frame_csum_q;
    assign o_locked        = locked_q;
    assign o_frameError    = frame_err_q;
    assign o_errorCount    = err_cnt_q;

endmodule

// File: tb/tb_hdp_stream_receiver.sv
// Self-checking bench for hdp_stream_receiver using a small frame geometry.
// Frames are built as per-cycle arrays; a frame-level reference model finds
// the first illegal cycle and predicts pixels, pulses, error count, lock and
// checksum from that.

module tb_hdp_stream_receiver;

    localparam int W = 4, B = 2, L = 3, P = 3, U = 5;
    localparam int LINE_LEN = W + B;
    localparam int FLEN = L * LINE_LEN + P;

    logic        clk;
    logic        i_nReset, i_enable, i_valid, i_update;
    logic [31:0] i_lcdData;
    logic [31:0] o_pixelData, o_frameChecksum;
    logic        o_pixelValid, o_lineDone, o_frameDone, o_locked, o_frameError;
    logic [15:0] o_wordIndex, o_lineIndex, o_errorCount;

    hdp_stream_receiver #(
        .WORDS_PER_LINE(W), .BLANK_PER_LINE(B), .LINES_PER_FRAME(L),
        .BACK_PORCH(P), .UPDATE_CYCLES(U)
    ) dut (
        .i_clock(clk), .i_nReset(i_nReset), .i_enable(i_enable),
        .i_lcdData(i_lcdData), .i_valid(i_valid), .i_update(i_update),
        .o_pixelData(o_pixelData), .o_pixelValid(o_pixelValid),
        .o_wordIndex(o_wordIndex), .o_lineIndex(o_lineIndex),
        .o_lineDone(o_lineDone), .o_frameDone(o_frameDone),
        .o_frameChecksum(o_frameChecksum), .o_locked(o_locked),
        .o_frameError(o_frameError), .o_errorCount(o_errorCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
`ifdef HDP_RX_CRC32_EN
    localparam logic [31:0] REF_INIT = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] REF_INIT = 32'h0;
`endif

    // CRC as polynomial remainder of ((acc ^ word) * x^32) mod G; sum otherwise
    function automatic logic [31:0] ref_acc(input logic [31:0] acc, input logic [31:0] w);
`ifdef HDP_RX_CRC32_EN
        logic [63:0] r;
        logic [63:0] g;
        r = {acc ^ w, 32'h0};
        for (int i = 63; i >= 32; i--) begin
            g = {31'h0, 33'h1_04C1_1DB7} << (i - 32);
            if (r[i]) r = r ^ g;
        end
        return r[31:0];
`else
        return acc + w;
`endif
    endfunction

    logic        fv[FLEN];
    logic        fu[FLEN];
    logic [31:0] fd[FLEN];

    logic [15:0] exp_err = 16'h0;
    logic [31:0] exp_csum = 32'h0;
    bit          model_locked = 1'b0;

    function automatic int kind_of(int c);   // 0 data, 1 blank, 2 porch
        if (c >= L * LINE_LEN) return 2;
        return ((c % LINE_LEN) < W) ? 0 : 1;
    endfunction

    task automatic build_clean(input bit seq);
        int n = 0;
        for (int c = 0; c < FLEN; c++) begin
            fu[c] = (c < U);
            if (kind_of(c) == 0) begin
                fv[c] = 1'b1;
                fd[c] = seq ? 32'(n + 1) : $urandom;
                n++;
            end else begin
                fv[c] = 1'b0;
                fd[c] = 32'h0;
            end
        end
    endtask

    // ---------------- output monitor ----------------
    typedef struct { logic [31:0] d; logic [15:0] w; logic [15:0] l; } pix_t;
    pix_t got_q[$];
    int   ld_cnt, fd_cnt, fe_cnt;
    bit   lock_low;

    always @(posedge clk) begin
        #1;
        if (o_pixelValid) got_q.push_back('{o_pixelData, o_wordIndex, o_lineIndex});
        if (o_lineDone)   ld_cnt++;
        if (o_frameDone)  fd_cnt++;
        if (o_frameError) fe_cnt++;
        if (!o_locked)    lock_low = 1'b1;
    end

    task automatic clear_mon();
        got_q.delete();
        ld_cnt = 0; fd_cnt = 0; fe_cnt = 0; lock_low = 1'b0;
    endtask

    task automatic drive(input logic v, input logic u, input logic [31:0] d, input logic en);
        @(negedge clk);
        i_valid = v; i_update = u; i_lcdData = d; i_enable = en;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic bump_err();
        if (exp_err != 16'hFFFF) exp_err = exp_err + 16'h1;
    endtask

    // Drive the frame held in fv/fu/fd (enable dropped from cycle dis_at) and
    // compare what the receiver reported against the frame-level prediction.
    task automatic run_and_check(input string tag, input int dis_at);
        int   v, cut, eld, efe;
        pix_t exp_q[$];
        logic [31:0] acc;
        bool_loop: begin end
        clear_mon();
        for (int c = 0; c < FLEN; c++) drive(fv[c], fu[c], fd[c], c < dis_at);
        settle();

        v = FLEN;
        for (int c = 0; c < FLEN; c++) begin
            bit ok;
            case (kind_of(c))
                0:       ok = fv[c] && (fu[c] == (c < U));
                1:       ok = !fv[c] && (fd[c] == 32'h0) && (fu[c] == (c < U));
                default: ok = !fv[c] && (fu[c] == (c < U));
            endcase
            if (v == FLEN && !ok) v = c;
        end
        cut = (v < dis_at) ? v : dis_at;

        acc = REF_INIT;
        for (int c = 0; c < cut; c++)
            if (kind_of(c) == 0) begin
                exp_q.push_back('{fd[c], 16'(c % LINE_LEN), 16'(c / LINE_LEN)});
                acc = ref_acc(acc, fd[c]);
            end
        eld = 0;
        for (int l = 0; l < L; l++) if (l * LINE_LEN + LINE_LEN - 1 < cut) eld++;
        efe = 0;
        if (v < FLEN && v < dis_at) begin efe = 1; bump_err(); end
        if (cut == FLEN) begin exp_csum = acc; model_locked = 1'b1; end
        else model_locked = 1'b0;

        check({tag, "_npix"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            check({tag, "_pixdata"}, got_q[k].d, exp_q[k].d);
            check({tag, "_wordidx"}, 32'(got_q[k].w), 32'(exp_q[k].w));
            check({tag, "_lineidx"}, 32'(got_q[k].l), 32'(exp_q[k].l));
        end
        check({tag, "_linedone"}, ld_cnt, eld);
        check({tag, "_framedone"}, fd_cnt, (cut == FLEN) ? 1 : 0);
        check({tag, "_frameerr"}, fe_cnt, efe);
        check({tag, "_errcount"}, 32'(o_errorCount), 32'(exp_err));
        check({tag, "_checksum"}, o_frameChecksum, exp_csum);
        check({tag, "_locked"}, 32'(o_locked), 32'(model_locked));
    endtask

    task automatic idle_step(input string tag, input int n);
        int efe = 0;
        clear_mon();
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 1'b1);
        settle();
        if (model_locked && n > 0) begin efe = 1; bump_err(); model_locked = 1'b0; end
        check({tag, "_frameerr"}, fe_cnt, efe);
        check({tag, "_errcount"}, 32'(o_errorCount), 32'(exp_err));
        check({tag, "_locked"}, 32'(o_locked), 32'(model_locked));
    endtask

    initial begin
        int ln, wd, kind;
        i_nReset = 1'b0; i_enable = 1'b1; i_valid = 1'b0; i_update = 1'b0; i_lcdData = 32'h0;
        clear_mon();
        #2;
        check("rst_locked", 32'(o_locked), 32'h0);
        check("rst_errcount", 32'(o_errorCount), 32'h0);
        check("rst_checksum", o_frameChecksum, 32'h0);
        check("rst_pixvalid", 32'(o_pixelValid), 32'h0);
        repeat (3) @(negedge clk);
        i_nReset = 1'b1;

        // clean frame of words 1..12
        build_clean(1'b1);
        run_and_check("clean_seq", FLEN);
`ifndef HDP_RX_CRC32_EN
        check("clean_seq_sum78", o_frameChecksum, 32'd78);
`endif

        // valid dropped on line 1 word 2, then clean relock
        build_clean(1'b0);
        fv[1 * LINE_LEN + 2] = 1'b0;
        run_and_check("drop_valid", FLEN);
        build_clean(1'b0);
        run_and_check("relock1", FLEN);

        // update held high for one extra cycle
        build_clean(1'b0);
        fu[U] = 1'b1;
        run_and_check("upd_long", FLEN);
        build_clean(1'b0);
        run_and_check("relock2", FLEN);

        // nonzero data in a blank cycle
        build_clean(1'b0);
        fd[$urandom_range(0, L - 1) * LINE_LEN + W + $urandom_range(0, B - 1)] = 32'hDEADBEEF;
        run_and_check("blank_data", FLEN);

        // valid asserted during porch
        build_clean(1'b0);
        ln = L * LINE_LEN + $urandom_range(0, P - 1);
        fv[ln] = 1'b1; fd[ln] = $urandom;
        run_and_check("porch_valid", FLEN);

        // two back-to-back clean frames keep lock
        build_clean(1'b0);
        run_and_check("b2b_a", FLEN);
        build_clean(1'b0);
        run_and_check("b2b_b", FLEN);
        check("b2b_lock_held", 32'(lock_low), 32'h0);

        // one idle cycle between frames, then relock
        idle_step("idle_gap", 1);
        build_clean(1'b0);
        run_and_check("relock3", FLEN);

        // enable dropped mid-frame, then relock
        build_clean(1'b0);
        run_and_check("disable", $urandom_range(7, 17));
        build_clean(1'b0);
        run_and_check("relock4", FLEN);

        // randomised frames with random faults
        for (int i = 0; i < 8; i++) begin
            build_clean(1'b0);
            kind = $urandom_range(0, 3);
            if (kind == 1) begin
                ln = $urandom_range(0, L - 1);
                wd = $urandom_range(0, W - 1);
                if (ln == 0 && wd == 0) wd = 1;
                fv[ln * LINE_LEN + wd] = 1'b0;
            end else if (kind == 2) begin
                fd[$urandom_range(0, L - 1) * LINE_LEN + W + $urandom_range(0, B - 1)] = $urandom | 32'h1;
            end else if (kind == 3) begin
                fv[L * LINE_LEN + $urandom_range(0, P - 1)] = 1'b1;
            end
            run_and_check("rand", FLEN);
        end

        // error counter saturation, starting just below the top
        idle_step("pre_sat", 1);
        @(negedge clk);
        force dut.err_cnt_q = 16'hFFFD;
        @(negedge clk);
        release dut.err_cnt_q;
        exp_err = 16'hFFFD;
        for (int i = 0; i < 4; i++) begin
            clear_mon();
            drive(1'b1, 1'b1, $urandom, 1'b1);
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            settle();
            bump_err();
            check("sat_errcount", 32'(o_errorCount), 32'(exp_err));
            check("sat_frameerr", fe_cnt, 1);
        end
        check("sat_top", 32'(o_errorCount), 32'h0000FFFF);
        model_locked = 1'b0;

        // asynchronous reset in the middle of a line
        build_clean(1'b0);
        for (int c = 0; c < LINE_LEN + 3; c++) drive(fv[c], fu[c], fd[c], 1'b1);
        #2;
        check("pre_rst_locked", 32'(o_locked), 32'h1);
        i_nReset = 1'b0;
        #1;
        check("arst_pixdata", o_pixelData, 32'h0);
        check("arst_pixvalid", 32'(o_pixelValid), 32'h0);
        check("arst_wordidx", 32'(o_wordIndex), 32'h0);
        check("arst_lineidx", 32'(o_lineIndex), 32'h0);
        check("arst_linedone", 32'(o_lineDone), 32'h0);
        check("arst_framedone", 32'(o_frameDone), 32'h0);
        check("arst_checksum", o_frameChecksum, 32'h0);
        check("arst_locked", 32'(o_locked), 32'h0);
        check("arst_frameerr", 32'(o_frameError), 32'h0);
        check("arst_errcount", 32'(o_errorCount), 32'h0);
        i_valid = 1'b0; i_update = 1'b0; i_lcdData = 32'h0;
        repeat (2) @(negedge clk);
        i_nReset = 1'b1;
        exp_err = 16'h0; exp_csum = 32'h0; model_locked = 1'b0;
        build_clean(1'b0);
        run_and_check("post_rst", FLEN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdp_stream_receiver.md
Name: hdp_stream_receiver

Overview:
- Panel-side receiver and checker for the HDP LCD output stream: consumes lcdData/valid/update, locks to frame timing and recovers pixel words with line/word coordinates.
- Flags framing violations and produces a per-frame checksum.
- Used on the loopback test board and in simulation as the golden sink for the LCD output path.
- Samples on rising edge of the HDP clock; the transmitter launches on the falling edge.

Parameters:
- WORDS_PER_LINE, 40, valid 32-bit packets per line (1280 px / 32)
- BLANK_PER_LINE, 4, valid-low packets after each line
- LINES_PER_FRAME, 1280, lines per frame
- BACK_PORCH, 24, valid-low cycles after the last line's blanking
- UPDATE_CYCLES, 28, cycles update is high at start of frame

Ports:
- i_clock  in  1  HDP clock (lcdClock)
- i_nReset  in  1  asynchronous, active-low reset
- i_enable  in  1  receiver enable; low forces hunt, no errors counted
- i_lcdData  in  32  HDP data
- i_valid  in  1  HDP valid
- i_update  in  1  HDP update
- o_pixelData  out  32  captured data word
- o_pixelValid  out  1  o_pixelData/indices qualify this cycle
- o_wordIndex  out  16  word position in line, 0..WORDS_PER_LINE-1
- o_lineIndex  out  16  line number, 0..LINES_PER_FRAME-1
- o_lineDone  out  1  1-cycle pulse after a line's last blank cycle
- o_frameDone  out  1  1-cycle pulse after the last porch cycle, if the frame had no error
- o_frameChecksum  out  32  checksum of last good frame, held
- o_locked  out  1  receiver is tracking frame timing
- o_frameError  out  1  1-cycle pulse on any violation
- o_errorCount  out  16  saturating violation count (stops at 0xFFFF)

Behaviour:
- Reset (async, i_nReset=0): state s_HUNT; all outputs 0, all counters 0, checksum 0. Reset mid-frame discards the frame with no pulses.
- Start of frame (SOF): i_update=1, previous-cycle i_update=0, and i_valid=1, in the same cycle.
- s_HUNT:
  - On SOF: capture word 0 and go to s_DATA with word counter 1, line 0, update counter 1.
  - Checksum restarts from word 0.
  - o_locked stays 0 until the first SOF.
- s_DATA:
  - Requires i_valid=1 every cycle.
  - Each word appears on o_pixelData/o_pixelValid one cycle after sampling, with its indices.
  - After word WORDS_PER_LINE-1, go to s_BLANK.
- s_BLANK:
  - Requires i_valid=0 and i_lcdData=0 for BLANK_PER_LINE cycles.
  - At the end, pulse o_lineDone.
  - Then go to s_PORCH if line==LINES_PER_FRAME-1, else to s_DATA with line+1.
- s_PORCH:
  - Requires i_valid=0 for BACK_PORCH cycles.
  - At the end, pulse o_frameDone and latch o_frameChecksum.
  - Then go to s_HUNT with o_locked held at 1.
  - If the next cycle is not SOF, record a violation and clear o_locked.
- Update check: i_update must be 1 for exactly the first UPDATE_CYCLES cycles of the frame, counting the SOF cycle, and 0 thereafter until the next SOF. Any mismatch is a violation.
- Violation:
  - Wrong valid, nonzero blank data or update mismatch.
  - Pulses o_frameError and increments o_errorCount (saturating).
  - Clears o_locked; goes to s_HUNT the next cycle.
  - No o_frameDone for that frame; checksum not latched.
- Simultaneous violation and SOF in s_HUNT: SOF wins only in s_HUNT. In other states an SOF is a violation.
- Checksum: 32-bit wrap-around sum of all data words in the frame.
- i_enable=0: next cycle s_HUNT, o_locked=0, no pulses, counters held; o_errorCount and o_frameChecksum retained.
- Width rule: index outputs are zero-extended to 16 bits.

Optional Feature:
- HDP_RX_CRC32_EN defined: o_frameChecksum is CRC-32.
  - Polynomial 0x04C11DB7, init 0xFFFFFFFF, 32-bit words processed MSB first, no reflection, no final XOR.
  - Computed in one cycle per word, latched identically.
- Undefined: additive sum as above. Port list is unchanged either way.

Test Plan:
- Use WORDS=4, BLANK=2, LINES=3, PORCH=3, UPDATE=5. Send a clean frame with words 1..12 -> o_pixelValid 12 times with indices (0,0)..(2,3); 3 o_lineDone pulses; o_frameDone once; checksum 78 (CRC build: matches reference model); o_locked=1; errorCount 0.
- Drop valid on line 1 word 2 -> o_frameError pulse and errorCount=1; o_locked=0; no o_frameDone; next clean frame relocks and checksum updates.
- Hold update high 6 cycles -> violation at cycle 6; errorCount increments by exactly 1.
- Send nonzero data (0xDEADBEEF) in a blank cycle -> violation; assert valid during porch -> violation; each adds 1.
- Send two back-to-back clean frames -> o_locked stays 1 throughout. Insert one idle cycle between frames -> violation and relock on the next SOF.
- Force errorCount to 0xFFFF via repeated violations -> holds 0xFFFF. Assert i_nReset low mid-line -> all outputs 0 immediately (asynchronous).
